// File: rtl/anode_scan_capture.sv
// Receive side of the multiplexed 7-seg scan bus: synchronises anode/code, filters glitches,
// demultiplexes into four held digits, and flags order, anode-legality and stale-scan faults.
module anode_scan_capture #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] anode_n,
    input  logic [3:0] code,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] digit4,
    output logic       frame_valid,
    output logic       frame_done,
    output logic       order_err,
    output logic       anode_err,
    output logic       stale
);

    localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] STAB_MAX  = SW'(STABLE_CYCLES);
    localparam logic [SW-1:0] STAB_ACC  = SW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    ANODE_OFF = 4'b1111;

    // Two-flop synchronisers
    logic [3:0] anode_s1_q, anode_s2_q;
    logic [3:0] code_s1_q, code_s2_q;

    // Stability filter
    logic [7:0]    pair_prev_q, pair_prev_d;
    logic [SW-1:0] stab_cnt_q, stab_cnt_d;
    logic          acc_flag_q, acc_flag_d;

    // Capture state
    logic [3:0]    digit_q [4];
    logic [3:0]    digit_d [4];
    logic [3:0]    captured_q, captured_d;
    logic [1:0]    last_idx_q, last_idx_d;
    logic          first_flag_q, first_flag_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    // Registered outputs
    logic frame_valid_q, frame_valid_d;
    logic frame_done_q, frame_done_d;
    logic order_err_q, order_err_d;
    logic anode_err_q, anode_err_d;
    logic stale_q, stale_d;

    logic [7:0] pair;
    logic       same;
    logic       accept;
    logic       is_onehot;
    logic       is_blank;
    logic [1:0] idx;
    logic [3:0] cap_next;

    assign pair = {anode_s2_q, code_s2_q};
    assign same = (pair == pair_prev_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            anode_s1_q <= ANODE_OFF;
            anode_s2_q <= ANODE_OFF;
            code_s1_q  <= 4'h0;
            code_s2_q  <= 4'h0;
        end else begin
            anode_s1_q <= anode_n;
            anode_s2_q <= anode_s1_q;
            code_s1_q  <= code;
            code_s2_q  <= code_s1_q;
        end
    end

    always_comb begin
        is_onehot = 1'b0;
        is_blank  = 1'b0;
        idx       = 2'd0;
        case (anode_s2_q)
            4'b1110: begin is_onehot = 1'b1; idx = 2'd0; end
            4'b1101: begin is_onehot = 1'b1; idx = 2'd1; end
            4'b1011: begin is_onehot = 1'b1; idx = 2'd2; end
            4'b0111: begin is_onehot = 1'b1; idx = 2'd3; end
            4'b1111: is_blank = 1'b1;
            default: ;
        endcase
    end

    // One acceptance per stable pattern; a change of the pair re-arms the filter.
    always_comb begin
        pair_prev_d = pair;
        if (!same) begin
            stab_cnt_d = '0;
        end else if (stab_cnt_q == STAB_MAX) begin
            stab_cnt_d = STAB_MAX;
        end else begin
            stab_cnt_d = stab_cnt_q + SW'(1);
        end
        accept     = same && !acc_flag_q && (stab_cnt_d >= STAB_ACC);
        acc_flag_d = same && (acc_flag_q || accept);
    end

    always_comb begin
        digit_d       = digit_q;
        captured_d    = captured_q;
        last_idx_d    = last_idx_q;
        first_flag_d  = first_flag_q;
        tmo_cnt_d     = tmo_cnt_q;
        frame_valid_d = frame_valid_q;
        stale_d       = stale_q;
        frame_done_d  = 1'b0;
        order_err_d   = 1'b0;
        anode_err_d   = 1'b0;
        cap_next      = captured_q | (4'b0001 << idx);

        if (accept && (is_onehot || is_blank)) begin
            tmo_cnt_d = '0;
            stale_d   = 1'b0;
        end else if (tmo_cnt_q == TMO_LAST) begin
            stale_d       = 1'b1;
            frame_valid_d = 1'b0;
            first_flag_d  = 1'b1;
            captured_d    = 4'h0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
        end

        if (accept && is_onehot) begin
            digit_d[idx] = code_s2_q;
            // Out-of-order digits are still stored; only the pulse reports them.
            order_err_d  = !first_flag_q && (idx != last_idx_q + 2'd1);
            last_idx_d   = idx;
            first_flag_d = 1'b0;
            if (cap_next == 4'hF) begin
                frame_done_d  = 1'b1;
                frame_valid_d = 1'b1;
                captured_d    = 4'h0;
            end else begin
                captured_d = cap_next;
            end
        end else if (accept && !is_blank) begin
            anode_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pair_prev_q   <= {ANODE_OFF, 4'h0};
            stab_cnt_q    <= '0;
            acc_flag_q    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                digit_q[i] <= 4'h0;
            end
            captured_q    <= 4'h0;
            last_idx_q    <= 2'd0;
            first_flag_q  <= 1'b1;
            tmo_cnt_q     <= '0;
            frame_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            order_err_q   <= 1'b0;
            anode_err_q   <= 1'b0;
            stale_q       <= 1'b0;
        end else begin
            pair_prev_q   <= pair_prev_d;
            stab_cnt_q    <= stab_cnt_d;
            acc_flag_q    <= acc_flag_d;
            digit_q       <= digit_d;
            captured_q    <= captured_d;
            last_idx_q    <= last_idx_d;
            first_flag_q  <= first_flag_d;
            tmo_cnt_q     <= tmo_cnt_d;
            frame_valid_q <= frame_valid_d;
            frame_done_q  <= frame_done_d;
            order_err_q   <= order_err_d;
            anode_err_q   <= anode_err_d;
            stale_q       <= stale_d;
        end
    end

    assign digit1      = digit_q[0];
    assign digit2      = digit_q[1];
    assign digit3      = digit_q[2];
    assign digit4      = digit_q[3];
    assign frame_valid = frame_valid_q;
    assign frame_done  = frame_done_q;
    assign order_err   = order_err_q;
    assign anode_err   = anode_err_q;
    assign stale       = stale_q;

endmodule
